// File: rtl/flag_window_monitor.sv
// Windowed statistics over the compare-stage flag stream: flag count, longest flag run and
// signed max/min of flagged samples, reported per window. Optional FLAG_MON_OVERFLOW_EN adds rep_ovf.
module flag_window_monitor #(
    parameter int WINDOW = 64,
    parameter int CNT_W  = 8
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic                    in_valid,
    input  logic                    in_flag,
    input  logic signed [6:0]       in_sample,
    output logic                    in_ready,
    output logic                    rep_valid,
    input  logic                    rep_ready,
    output logic [CNT_W-1:0]        rep_count,
    output logic [CNT_W-1:0]        rep_maxrun,
    output logic signed [6:0]       rep_max,
    output logic signed [6:0]       rep_min
`ifdef FLAG_MON_OVERFLOW_EN
    ,
    output logic                    rep_ovf
`endif
);

    localparam int IDX_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WINDOW - 1);
    // Empty-window sentinels: max starts at the most negative value, min at the most positive.
    localparam logic signed [6:0] MAX_INIT = 7'sh40;
    localparam logic signed [6:0] MIN_INIT = 7'sh3F;

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  run_r;
    logic [CNT_W-1:0]  maxrun_r;
    logic signed [6:0] max_r;
    logic signed [6:0] min_r;

    logic [CNT_W-1:0]  count_nxt_s;
    logic [CNT_W-1:0]  run_nxt_s;
    logic [CNT_W-1:0]  maxrun_nxt_s;
    logic signed [6:0] max_nxt_s;
    logic signed [6:0] min_nxt_s;

`ifdef FLAG_MON_OVERFLOW_EN
    logic ovf_r;
    logic ovf_nxt_s;
`endif

    // Accumulator values after accepting the current sample (only used when a sample is accepted).
    always_comb begin
        count_nxt_s  = count_r;
        run_nxt_s    = run_r;
        maxrun_nxt_s = maxrun_r;
        max_nxt_s    = max_r;
        min_nxt_s    = min_r;
`ifdef FLAG_MON_OVERFLOW_EN
        ovf_nxt_s    = ovf_r;
`endif
        if (in_flag) begin
            count_nxt_s = (count_r == CNT_MAX) ? CNT_MAX : count_r + CNT_ONE;
            run_nxt_s   = (run_r == CNT_MAX) ? CNT_MAX : run_r + CNT_ONE;
            if (run_nxt_s > maxrun_r) begin
                maxrun_nxt_s = run_nxt_s;
            end else begin
                maxrun_nxt_s = maxrun_r;
            end
            if (in_sample > max_r) begin
                max_nxt_s = in_sample;
            end else begin
                max_nxt_s = max_r;
            end
            if (in_sample < min_r) begin
                min_nxt_s = in_sample;
            end else begin
                min_nxt_s = min_r;
            end
`ifdef FLAG_MON_OVERFLOW_EN
            if ((count_r == CNT_MAX) || (run_r == CNT_MAX)) begin
                ovf_nxt_s = 1'b1;
            end else begin
                ovf_nxt_s = ovf_r;
            end
`endif
        end else begin
            run_nxt_s = CNT_ZERO;
        end
    end

    // Window FSM: accumulate WINDOW accepts, then hold the report until the consumer takes it.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_r    <= ST_ACCUM;
            in_ready   <= 1'b1;
            rep_valid  <= 1'b0;
            idx_r      <= IDX_ZERO;
            count_r    <= CNT_ZERO;
            run_r      <= CNT_ZERO;
            maxrun_r   <= CNT_ZERO;
            max_r      <= MAX_INIT;
            min_r      <= MIN_INIT;
            rep_count  <= CNT_ZERO;
            rep_maxrun <= CNT_ZERO;
            rep_max    <= MAX_INIT;
            rep_min    <= MIN_INIT;
`ifdef FLAG_MON_OVERFLOW_EN
            ovf_r      <= 1'b0;
            rep_ovf    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (in_valid) begin
                        idx_r    <= idx_r + IDX_ONE;
                        count_r  <= count_nxt_s;
                        run_r    <= run_nxt_s;
                        maxrun_r <= maxrun_nxt_s;
                        max_r    <= max_nxt_s;
                        min_r    <= min_nxt_s;
`ifdef FLAG_MON_OVERFLOW_EN
                        ovf_r    <= ovf_nxt_s;
`endif
                        if (idx_r == IDX_LAST) begin
                            rep_count  <= count_nxt_s;
                            rep_maxrun <= maxrun_nxt_s;
                            rep_max    <= max_nxt_s;
                            rep_min    <= min_nxt_s;
`ifdef FLAG_MON_OVERFLOW_EN
                            rep_ovf    <= ovf_nxt_s;
`endif
                            state_r    <= ST_REPORT;
                            in_ready   <= 1'b0;
                            rep_valid  <= 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    if (rep_ready) begin
                        state_r   <= ST_ACCUM;
                        in_ready  <= 1'b1;
                        rep_valid <= 1'b0;
                        idx_r     <= IDX_ZERO;
                        count_r   <= CNT_ZERO;
                        run_r     <= CNT_ZERO;
                        maxrun_r  <= CNT_ZERO;
                        max_r     <= MAX_INIT;
                        min_r     <= MIN_INIT;
`ifdef FLAG_MON_OVERFLOW_EN
                        ovf_r     <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r   <= ST_ACCUM;
                    in_ready  <= 1'b1;
                    rep_valid <= 1'b0;
                    idx_r     <= IDX_ZERO;
                    count_r   <= CNT_ZERO;
                    run_r     <= CNT_ZERO;
                    maxrun_r  <= CNT_ZERO;
                    max_r     <= MAX_INIT;
                    min_r     <= MIN_INIT;
`ifdef FLAG_MON_OVERFLOW_EN
                    ovf_r     <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flag_window_monitor.sv
// Directed bench for flag_window_monitor: a WINDOW=4/CNT_W=8 instance and a WINDOW=6/CNT_W=2 instance.
module tb_flag_window_monitor;

    logic              clk;
    logic              rstn;
    logic              in_valid, in_flag, in_ready, rep_valid, rep_ready;
    logic signed [6:0] in_sample, rep_max, rep_min;
    logic [7:0]        rep_count, rep_maxrun;
    logic              in_valid2, in_flag2, in_ready2, rep_valid2, rep_ready2;
    logic signed [6:0] in_sample2, rep_max2, rep_min2;
    logic [1:0]        rep_count2, rep_maxrun2;
`ifdef FLAG_MON_OVERFLOW_EN
    logic              rep_ovf, rep_ovf2;
`endif

    int checks = 0;
    int failures = 0;

    flag_window_monitor #(.WINDOW(4), .CNT_W(8)) dut (
        .system1000(clk), .system1000_rstn(rstn),
        .in_valid(in_valid), .in_flag(in_flag), .in_sample(in_sample), .in_ready(in_ready),
        .rep_valid(rep_valid), .rep_ready(rep_ready), .rep_count(rep_count),
        .rep_maxrun(rep_maxrun), .rep_max(rep_max), .rep_min(rep_min)
`ifdef FLAG_MON_OVERFLOW_EN
        , .rep_ovf(rep_ovf)
`endif
    );

    flag_window_monitor #(.WINDOW(6), .CNT_W(2)) dut2 (
        .system1000(clk), .system1000_rstn(rstn),
        .in_valid(in_valid2), .in_flag(in_flag2), .in_sample(in_sample2), .in_ready(in_ready2),
        .rep_valid(rep_valid2), .rep_ready(rep_ready2), .rep_count(rep_count2),
        .rep_maxrun(rep_maxrun2), .rep_max(rep_max2), .rep_min(rep_min2)
`ifdef FLAG_MON_OVERFLOW_EN
        , .rep_ovf(rep_ovf2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic signed [6:0] obs, input logic signed [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic f, input logic signed [6:0] v);
        in_valid  = 1'b1;
        in_flag   = f;
        in_sample = v;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic send2(input logic f, input logic signed [6:0] v);
        in_valid2  = 1'b1;
        in_flag2   = f;
        in_sample2 = v;
        step();
        in_valid2  = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0; in_flag = 1'b0; in_sample = 7'sd0; rep_ready = 1'b0;
        in_valid2 = 1'b0; in_flag2 = 1'b0; in_sample2 = 7'sd0; rep_ready2 = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_rep_valid", rep_valid, 32'd0);
        chk("rst_count", rep_count, 32'd0);
        chk("rst_maxrun", rep_maxrun, 32'd0);
        chk_s("rst_max", rep_max, 7'sh40);
        chk_s("rst_min", rep_min, 7'sd63);
        rstn = 1'b1;

        // Basic window with one-cycle report latency
        rep_ready = 1'b1;
        send(1'b1, 7'sd5);
        send(1'b1, -7'sd3);
        send(1'b0, 7'sd60);
        chk("t1_no_early_valid", rep_valid, 32'd0);
        send(1'b1, 7'sd20);
        chk("t1_valid", rep_valid, 32'd1);
        chk("t1_in_ready_low", in_ready, 32'd0);
        chk("t1_count", rep_count, 32'd3);
        chk("t1_maxrun", rep_maxrun, 32'd2);
        chk_s("t1_max", rep_max, 7'sd20);
        chk_s("t1_min", rep_min, -7'sd3);
        step();
        chk("t1_valid_drop", rep_valid, 32'd0);
        chk("t1_in_ready_back", in_ready, 32'd1);
        chk("t1_count_hold", rep_count, 32'd3);

        // Window without flags reports the sentinels
        send(1'b0, 7'sd1);
        send(1'b0, -7'sd60);
        send(1'b0, 7'sd62);
        send(1'b0, 7'sd0);
        chk("t2_valid", rep_valid, 32'd1);
        chk("t2_count", rep_count, 32'd0);
        chk("t2_maxrun", rep_maxrun, 32'd0);
        chk_s("t2_max", rep_max, 7'sh40);
        chk_s("t2_min", rep_min, 7'sd63);
        step();

        // Backpressure on the report port
        rep_ready = 1'b0;
        send(1'b1, 7'sd10);
        send(1'b1, 7'sd11);
        send(1'b1, -7'sd12);
        send(1'b0, 7'sd0);
        in_valid = 1'b1; in_flag = 1'b1; in_sample = 7'sd50;
        for (int i = 0; i < 10; i++) begin
            chk("t3_in_ready_low", in_ready, 32'd0);
            chk("t3_valid_held", rep_valid, 32'd1);
            chk("t3_count_held", rep_count, 32'd3);
            chk("t3_maxrun_held", rep_maxrun, 32'd3);
            chk_s("t3_max_held", rep_max, 7'sd11);
            chk_s("t3_min_held", rep_min, -7'sd12);
            step();
        end
        in_valid = 1'b0;
        rep_ready = 1'b1;
        step();
        chk("t3_valid_drop", rep_valid, 32'd0);
        chk("t3_in_ready_back", in_ready, 32'd1);
        send(1'b1, 7'sd50);
        send(1'b0, 7'sd1);
        send(1'b1, -7'sd1);
        send(1'b1, 7'sd2);
        chk("t3b_valid", rep_valid, 32'd1);
        chk("t3b_count", rep_count, 32'd3);
        chk("t3b_maxrun", rep_maxrun, 32'd2);
        chk_s("t3b_max", rep_max, 7'sd50);
        chk_s("t3b_min", rep_min, -7'sd1);
        step();

        // Runs do not carry across the window boundary
        send(1'b0, 7'sd0);
        send(1'b0, 7'sd0);
        send(1'b1, 7'sd4);
        send(1'b1, 7'sd4);
        chk("t4_w1_maxrun", rep_maxrun, 32'd2);
        step();
        send(1'b1, 7'sd9);
        send(1'b0, 7'sd0);
        send(1'b0, 7'sd0);
        send(1'b0, 7'sd0);
        chk("t4_w2_valid", rep_valid, 32'd1);
        chk("t4_w2_maxrun", rep_maxrun, 32'd1);
        chk("t4_w2_count", rep_count, 32'd1);
        step();

        // Reset in the middle of a window discards it
        send(1'b1, -7'sd50);
        send(1'b1, 7'sd60);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_in_ready", in_ready, 32'd1);
        chk("t5_rst_count", rep_count, 32'd0);
        chk_s("t5_rst_max", rep_max, 7'sh40);
        chk_s("t5_rst_min", rep_min, 7'sd63);
        rstn = 1'b1;
        send(1'b1, 7'sd7);
        send(1'b1, 7'sd7);
        send(1'b1, 7'sd7);
        send(1'b1, 7'sd7);
        chk("t5_valid", rep_valid, 32'd1);
        chk("t5_count", rep_count, 32'd4);
        chk("t5_maxrun", rep_maxrun, 32'd4);
        chk_s("t5_max", rep_max, 7'sd7);
        chk_s("t5_min", rep_min, 7'sd7);
        step();

        // Saturation with CNT_W=2, WINDOW=6
        rep_ready2 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            chk("t6_no_early_valid", rep_valid2, 32'd0);
            send2(1'b1, 7'(i));
        end
        chk("t6_valid", rep_valid2, 32'd1);
        chk("t6_count_sat", rep_count2, 32'd3);
        chk("t6_maxrun_sat", rep_maxrun2, 32'd3);
        chk_s("t6_max", rep_max2, 7'sd6);
        chk_s("t6_min", rep_min2, 7'sd1);
`ifdef FLAG_MON_OVERFLOW_EN
        chk("t6_ovf", rep_ovf2, 32'd1);
`endif
        step();
        send2(1'b1, -7'sd5);
        send2(1'b0, 7'sd0);
        send2(1'b1, 7'sd3);
        send2(1'b0, 7'sd0);
        send2(1'b0, 7'sd0);
        send2(1'b0, 7'sd0);
        chk("t7_valid", rep_valid2, 32'd1);
        chk("t7_count", rep_count2, 32'd2);
        chk("t7_maxrun", rep_maxrun2, 32'd1);
        chk_s("t7_max", rep_max2, 7'sd3);
        chk_s("t7_min", rep_min2, -7'sd5);
`ifdef FLAG_MON_OVERFLOW_EN
        chk("t7_ovf_clear", rep_ovf2, 32'd0);
`endif
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
